// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-8 registered word demultiplexer.
package demux_pkg;
  localparam int WIDTH = 16;
  localparam int N_OUT = 8;
  localparam int SEL_W = $clog2(N_OUT);

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/demux_out_slot.sv
// One output channel: a word register plus its valid flag, filled by the
// distributor and drained by the channel's consumer.
module demux_out_slot
  import demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  fill,
  input  logic  drain,
  input  word_t fill_data,
  output word_t data,
  output logic  valid
);

  word_t data_reg;
  logic  valid_reg;

  // A fill wins over a drain, so a word taken and replaced in one cycle keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (fill) begin
      data_reg  <= fill_data;
      valid_reg <= 1'b1;
    end else if (drain) begin
      valid_reg <= 1'b0;
    end
  end

  assign data  = data_reg;
  assign valid = valid_reg;

endmodule

// File: rtl/demux_1x8_16_buf.sv
// Registered 1-to-8 demultiplexer: routes each accepted word to one buffered
// output channel, either by in_sel or by an internal TDM sequence counter.
module demux_1x8_16_buf
  import demux_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  word_t                  in_data,
  input  sel_t                   in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   auto_mode,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output sel_t                   seq_cnt,
  output logic                   frame_done
);

  sel_t             dest;
  logic             dest_ok;
  logic             accept;
  logic [N_OUT-1:0] fill;
  sel_t             seq_cnt_reg;
  logic             frame_done_reg;

  assign dest = auto_mode ? seq_cnt_reg : in_sel;

  // Only a select code beyond the last channel can be unreachable.
  generate
    if (N_OUT < (1 << SEL_W)) begin : g_partial_sel
      assign dest_ok = (int'(dest) < N_OUT);
    end else begin : g_full_sel
      assign dest_ok = 1'b1;
    end
  endgenerate

  assign in_ready = dest_ok & (~out_valid[dest] | out_ready[dest]);
  assign accept   = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_slot
      assign fill[gi] = accept && (dest == sel_t'(gi));

      demux_out_slot u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .fill      (fill[gi]),
        .drain     (out_ready[gi]),
        .fill_data (in_data),
        .data      (out_data[gi*WIDTH +: WIDTH]),
        .valid     (out_valid[gi])
      );
    end
  endgenerate

  // Leaving auto mode abandons any partial frame by parking the counter at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_cnt_reg    <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= auto_mode && accept && (seq_cnt_reg == sel_t'(N_OUT - 1));
      if (!auto_mode) begin
        seq_cnt_reg <= '0;
      end else if (accept) begin
        seq_cnt_reg <= (seq_cnt_reg == sel_t'(N_OUT - 1)) ? '0 : seq_cnt_reg + 1'b1;
      end
    end
  end

  assign seq_cnt    = seq_cnt_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_demux_1x8_16_buf.sv
// Self-checking bench: fixed vector table, hand-written auto-mode sequences,
// and a randomized run against a channel-array reference model.
module tb_demux_1x8_16_buf;
  import demux_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [15:0]            in_data;
  logic [2:0]             in_sel;
  logic                   in_valid;
  logic                   in_ready;
  logic                   auto_mode;
  logic [127:0]           out_data;
  logic [7:0]             out_valid;
  logic [7:0]             out_ready;
  logic [2:0]             seq_cnt;
  logic                   frame_done;

  demux_1x8_16_buf dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .auto_mode  (auto_mode),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .seq_cnt    (seq_cnt),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one word and one full flag per channel, plus a frame position.
  logic [15:0] md [8];
  bit          mv [8];
  int          mseq;
  bit          mfd;
  bit          rdy_seen;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      md[k] = '0;
      mv[k] = 1'b0;
    end
    mseq = 0;
    mfd  = 1'b0;
  endtask

  function automatic logic [7:0] exp_valid();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = mv[k];
    return v;
  endfunction

  function automatic logic [127:0] exp_data();
    logic [127:0] d;
    for (int k = 0; k < 8; k++) d[k*16 +: 16] = md[k];
    return d;
  endfunction

  // One clock: check in_ready before the edge, advance the model, check state after.
  task automatic step(input string tag);
    int  dest;
    bit  rdy;
    bit  acc;
    #1;
    dest = auto_mode ? mseq : int'(in_sel);
    rdy  = !mv[dest] || out_ready[dest];
    acc  = in_valid && rdy;
    rdy_seen = in_ready;
    chk({tag, " in_ready"}, 128'(in_ready), 128'(rdy));
    @(posedge clk);
    for (int k = 0; k < 8; k++)
      if (mv[k] && out_ready[k]) mv[k] = 1'b0;
    if (acc) begin
      md[dest] = in_data;
      mv[dest] = 1'b1;
    end
    mfd  = auto_mode && acc && (mseq == 7);
    mseq = !auto_mode ? 0 : (acc ? (mseq + 1) % 8 : mseq);
    if (acc)
      $display("%s: auto=%0b ch=%0d data=%h accepted", tag, auto_mode, dest, in_data);
    @(negedge clk);
    chk({tag, " out_valid"},  128'(out_valid),  128'(exp_valid()));
    chk({tag, " out_data"},   out_data,         exp_data());
    chk({tag, " seq_cnt"},    128'(seq_cnt),    128'(mseq));
    chk({tag, " frame_done"}, 128'(frame_done), 128'(mfd));
  endtask

  task automatic drive(input bit am, input logic [2:0] sel, input logic [15:0] data,
                       input bit iv, input logic [7:0] ord);
    auto_mode = am;
    in_sel    = sel;
    in_data   = data;
    in_valid  = iv;
    out_ready = ord;
  endtask

  typedef struct {
    bit          am;
    logic [2:0]  sel;
    logic [15:0] data;
    bit          iv;
    logic [7:0]  ord;
    bit          e_rdy;
    logic [7:0]  e_valid;
    int          e_ch;
    logic [15:0] e_word;
  } vec_t;

  vec_t vecs [9];

  initial begin
    // Direct fill, stall, drain+refill, and pass-through to a continuously ready consumer.
    vecs[0] = '{1'b0, 3'd5, 16'hBEEF, 1'b1, 8'h00, 1'b1, 8'h20, 5, 16'hBEEF};
    vecs[1] = '{1'b0, 3'd5, 16'h1234, 1'b1, 8'h00, 1'b0, 8'h20, 5, 16'hBEEF};
    vecs[2] = '{1'b0, 3'd5, 16'h1234, 1'b1, 8'h20, 1'b1, 8'h20, 5, 16'h1234};
    vecs[3] = '{1'b0, 3'd2, 16'h1111, 1'b1, 8'h04, 1'b1, 8'h24, 2, 16'h1111};
    vecs[4] = '{1'b0, 3'd2, 16'h2222, 1'b1, 8'h04, 1'b1, 8'h24, 2, 16'h2222};
    vecs[5] = '{1'b0, 3'd2, 16'h3333, 1'b1, 8'h04, 1'b1, 8'h24, 2, 16'h3333};
    vecs[6] = '{1'b0, 3'd2, 16'h4444, 1'b1, 8'h04, 1'b1, 8'h24, 2, 16'h4444};
    vecs[7] = '{1'b0, 3'd2, 16'h5555, 1'b0, 8'h24, 1'b1, 8'h00, 2, 16'h4444};
    vecs[8] = '{1'b0, 3'd0, 16'h6666, 1'b0, 8'h00, 1'b1, 8'h00, 5, 16'h1234};

    rst_n = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 1'b0, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid",  128'(out_valid),  128'h0);
    chk("reset out_data",   out_data,         128'h0);
    chk("reset seq_cnt",    128'(seq_cnt),    128'h0);
    chk("reset frame_done", 128'(frame_done), 128'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].am, vecs[i].sel, vecs[i].data, vecs[i].iv, vecs[i].ord);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl in_ready", i), 128'(rdy_seen), 128'(vecs[i].e_rdy));
      chk($sformatf("vec%0d tbl out_valid", i), 128'(out_valid), 128'(vecs[i].e_valid));
      chk($sformatf("vec%0d tbl word", i), 128'(out_data[vecs[i].e_ch*16 +: 16]),
          128'(vecs[i].e_word));
    end

    // Auto mode: a full frame lands in channel order with a single frame_done pulse.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 3'd0, 16'h0100 + 16'(k), 1'b1, 8'h00);
      step($sformatf("auto%0d", k));
      chk($sformatf("auto%0d frame_done", k), 128'(frame_done), 128'(k == 7));
    end
    chk("auto seq wrap", 128'(seq_cnt), 128'h0);
    for (int k = 0; k < 8; k++)
      chk($sformatf("auto ch%0d word", k), 128'(out_data[k*16 +: 16]), 128'(16'h0100 + 16'(k)));
    drive(1'b1, 3'd0, 16'h0, 1'b0, 8'h00);
    step("auto idle");
    chk("auto pulse end", 128'(frame_done), 128'h0);

    // Auto backpressure: channel 3 stays full until its consumer frees it.
    drive(1'b1, 3'd0, 16'h0, 1'b0, 8'hF7);
    step("bp drain");
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'd0, 16'h0200 + 16'(k), 1'b1, 8'h00);
      step($sformatf("bp%0d", k));
    end
    drive(1'b1, 3'd0, 16'h0203, 1'b1, 8'h00);
    for (int s = 0; s < 2; s++) begin
      step($sformatf("bp stall%0d", s));
      chk($sformatf("bp stall%0d in_ready", s), 128'(rdy_seen), 128'h0);
      chk($sformatf("bp stall%0d seq", s), 128'(seq_cnt), 128'h3);
    end
    drive(1'b1, 3'd0, 16'h0203, 1'b1, 8'h08);
    step("bp release");
    chk("bp release word", 128'(out_data[3*16 +: 16]), 128'h0203);
    chk("bp release seq", 128'(seq_cnt), 128'h4);

    // Abort at seq_cnt=4: counter returns to 0, filled channels keep their words.
    drive(1'b0, 3'd0, 16'h0204, 1'b0, 8'h00);
    step("abort");
    chk("abort seq", 128'(seq_cnt), 128'h0);
    chk("abort frame_done", 128'(frame_done), 128'h0);
    for (int k = 0; k < 4; k++)
      chk($sformatf("abort ch%0d word", k), 128'(out_data[k*16 +: 16]), 128'(16'h0200 + 16'(k)));

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 15) != 0) ? auto_mode : ~auto_mode,
            3'($urandom_range(0, 7)), 16'($urandom), ($urandom_range(0, 3) != 0),
            8'($urandom));
      step($sformatf("rnd%0d", i));
    end

    // Reset mid-stream clears everything without waiting for a clock edge.
    drive(1'b0, 3'd0, 16'h0, 1'b0, 8'hFF);
    step("pre clear");
    drive(1'b0, 3'd1, 16'hA001, 1'b1, 8'h00);
    step("pre w1");
    drive(1'b0, 3'd6, 16'hA006, 1'b1, 8'h00);
    step("pre w6");
    drive(1'b1, 3'd0, 16'hA000, 1'b1, 8'h00);
    step("pre w0");
    chk("pre reset valid", 128'(out_valid), 128'h43);
    chk("pre reset seq", 128'(seq_cnt), 128'h1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async reset out_valid",  128'(out_valid),  128'h0);
    chk("async reset out_data",   out_data,         128'h0);
    chk("async reset seq_cnt",    128'(seq_cnt),    128'h0);
    chk("async reset frame_done", 128'(frame_done), 128'h0);
    @(negedge clk);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 8'h00);
    rst_n = 1'b1;
    drive(1'b0, 3'd4, 16'hC0DE, 1'b1, 8'h00);
    step("post reset");
    chk("post reset word", 128'(out_data[4*16 +: 16]), 128'hC0DE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
